// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative multiply/divide unit that owns the HI/LO registers.
//
// Operations (op): 00 MULT, 01 MULTU, 10 DIV, 11 DIVU. Multiplication is a
// shift-add that takes one multiplier bit per cycle. Division is restoring and
// produces one quotient bit per cycle. Both work on magnitudes, and the signs
// are applied in a final fix-up cycle.
//
// Optional build macro: MULDIV_EARLY_EXIT_EN. When it is defined, a multiply
// leaves CALC as soon as the remaining multiplier bits are all zero. Without
// it, every multiply spends exactly N cycles in CALC. Divide is the same
// either way.
//
// Ports:
//   clk     system clock, rising edge
//   reset   asynchronous active-high reset
//   start   launch an operation (sampled only in IDLE)
//   op      operation select (captured with start)
//   a, b    rs / rt operands
//   rd_req  MFHI/MFLO in flight; stalls while busy
//   hi_we   MTHI write strobe
//   lo_we   MTLO write strobe
//   wdata   MTHI/MTLO data
//   hi, lo  HI/LO registers
//   busy    high in LOAD, CALC and FIX
//   done    one-cycle pulse in the cycle that HI/LO hold a new result
//   stall   busy & (rd_req | start | hi_we | lo_we)
module muldiv_seq #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         rd_req,
  input  logic         hi_we,
  input  logic         lo_we,
  input  logic [N-1:0] wdata,
  output logic [N-1:0] hi,
  output logic [N-1:0] lo,
  output logic         busy,
  output logic         done,
  output logic         stall
);

  localparam int CW = $clog2(N);

`ifdef MULDIV_EARLY_EXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, LOAD, CALC, FIX, DONE} state_t;

  state_t         state_reg;
  logic [1:0]     op_reg;
  logic [N-1:0]   a_raw_reg;
  logic [N-1:0]   b_raw_reg;
  logic [2*N-1:0] prod_reg;
  logic [2*N-1:0] mcand_reg;
  logic [N-1:0]   mplier_reg;
  logic [N-1:0]   rem_reg;
  logic [N-1:0]   quo_reg;
  logic [N-1:0]   dvsr_reg;
  logic           res_neg_reg;
  logic           rem_neg_reg;
  logic [CW-1:0]  cnt_reg;

  // Operand conditioning, evaluated in LOAD from the operands captured at start.
  logic         is_div;
  logic         is_signed;
  logic         a_neg;
  logic         b_neg;
  logic [N-1:0] a_mag;
  logic [N-1:0] b_mag;

  assign is_div    = op_reg[1];
  assign is_signed = ~op_reg[0];
  assign a_neg     = is_signed & a_raw_reg[N-1];
  assign b_neg     = is_signed & b_raw_reg[N-1];
  assign a_mag     = a_neg ? (~a_raw_reg + 1'b1) : a_raw_reg;
  assign b_mag     = b_neg ? (~b_raw_reg + 1'b1) : b_raw_reg;

  // Multiply step: add the shifted multiplicand when the current multiplier bit is set.
  logic [N-1:0]   mplier_shift;
  logic [2*N-1:0] prod_sum;
  logic           mul_last;

  assign mplier_shift = mplier_reg >> 1;
  assign prod_sum     = mplier_reg[0] ? (prod_reg + mcand_reg) : prod_reg;
  assign mul_last     = (cnt_reg == '0) | (EARLY_EXIT & (mplier_shift == '0));

  // Restoring divide step on an N+1-bit partial remainder. The extra top bit
  // of the difference is the borrow. Bit N of a non-negative difference is
  // always zero, because the remainder stays below the divisor. Folding that
  // bit into rem_ok keeps the test exact.
  logic [N:0]   rem_shift;
  logic [N+1:0] rem_diff;
  logic         rem_ok;

  assign rem_shift = {rem_reg, quo_reg[N-1]};
  assign rem_diff  = {1'b0, rem_shift} - {2'b00, dvsr_reg};
  assign rem_ok    = ~rem_diff[N+1] & ~rem_diff[N];

  // Sign fix-up values that are written to HI/LO when FIX completes.
  logic [2*N-1:0] prod_fix;
  logic [N-1:0]   quo_fix;
  logic [N-1:0]   rem_fix;

  assign prod_fix = res_neg_reg ? (~prod_reg + 1'b1) : prod_reg;
  assign quo_fix  = res_neg_reg ? (~quo_reg + 1'b1) : quo_reg;
  assign rem_fix  = rem_neg_reg ? (~rem_reg + 1'b1) : rem_reg;

  assign stall = busy & (rd_req | start | hi_we | lo_we);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      op_reg      <= '0;
      a_raw_reg   <= '0;
      b_raw_reg   <= '0;
      prod_reg    <= '0;
      mcand_reg   <= '0;
      mplier_reg  <= '0;
      rem_reg     <= '0;
      quo_reg     <= '0;
      dvsr_reg    <= '0;
      res_neg_reg <= 1'b0;
      rem_neg_reg <= 1'b0;
      cnt_reg     <= '0;
      hi          <= '0;
      lo          <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            // start takes priority over any MT write in the same cycle.
            op_reg    <= op;
            a_raw_reg <= a;
            b_raw_reg <= b;
            busy      <= 1'b1;
            state_reg <= LOAD;
          end else begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
          end
        end

        LOAD: begin
          res_neg_reg <= a_neg ^ b_neg;
          rem_neg_reg <= a_neg;
          cnt_reg     <= CW'(N - 1);
          if (is_div) begin
            rem_reg  <= '0;
            quo_reg  <= a_mag;
            dvsr_reg <= b_mag;
            if (b_raw_reg == '0) begin
              // Divide by zero short-circuits and returns the raw dividend as the remainder.
              lo        <= '1;
              hi        <= a_raw_reg;
              done      <= 1'b1;
              busy      <= 1'b0;
              state_reg <= DONE;
            end else begin
              state_reg <= CALC;
            end
          end else begin
            prod_reg   <= '0;
            mcand_reg  <= {{N{1'b0}}, a_mag};
            mplier_reg <= b_mag;
            state_reg  <= CALC;
          end
        end

        CALC: begin
          cnt_reg <= cnt_reg - 1'b1;
          if (is_div) begin
            rem_reg <= rem_ok ? rem_diff[N-1:0] : rem_shift[N-1:0];
            quo_reg <= {quo_reg[N-2:0], rem_ok};
            if (cnt_reg == '0) state_reg <= FIX;
          end else begin
            prod_reg   <= prod_sum;
            mcand_reg  <= mcand_reg << 1;
            mplier_reg <= mplier_shift;
            if (mul_last) state_reg <= FIX;
          end
        end

        FIX: begin
          if (is_div) begin
            lo <= quo_fix;
            hi <= rem_fix;
          end else begin
            hi <= prod_fix[2*N-1:N];
            lo <= prod_fix[N-1:0];
          end
          done      <= 1'b1;
          busy      <= 1'b0;
          state_reg <= DONE;
        end

        DONE: begin
          // HI/LO already hold the result, so a later MT write may land here.
          if (!start) begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
          end
          state_reg <= IDLE;
        end

        default: begin
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule
